// File: rtl/mixer_pkg.sv
// rtl/mixer_pkg.sv - shared constants and helpers for the signal mixer
package mixer_pkg;

  localparam int CH_MAX = 16;

  // Adder width large enough that NUM_CH samples plus a carry-in never wrap.
  function automatic int sum_width(input int width, input int num_ch);
    return width + $clog2(num_ch + 1);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/mixer_adder_tree.sv
// rtl/mixer_adder_tree.sv - combinational sum of NUM_CH masked samples plus carry-in
module mixer_adder_tree
  import mixer_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SUM_W  = sum_width(WIDTH, NUM_CH)
) (
  input  logic [NUM_CH*WIDTH-1:0] samples_i,
  input  logic                    cin_i,
  output logic [SUM_W-1:0]        sum_o
);

  logic [SUM_W-1:0] acc;

  always_comb begin
    acc = SUM_W'(cin_i);
    for (int k = 0; k < NUM_CH; k++) begin
      acc = acc + SUM_W'(samples_i[k*WIDTH +: WIDTH]);
    end
    sum_o = acc;
  end

endmodule

// File: rtl/signal_mixer.sv
// rtl/signal_mixer.sv - two-stage N-channel mixer with valid/ready handshake and overflow count
// Define MIXER_SATURATE_EN to clamp out_data to all-ones on overflow.
module signal_mixer
  import mixer_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_mask,
  input  logic                    in_cin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_carry,
  output logic [CNT_W-1:0]        ovf_count
);

  localparam int SUM_W = sum_width(WIDTH, NUM_CH);
  localparam logic [CNT_W-1:0] CNT_ONES = '1;

  logic                    s1_valid_q, s1_valid_d;
  logic [NUM_CH*WIDTH-1:0] s1_data_q, s1_data_d;
  logic                    s1_cin_q, s1_cin_d;
  logic                    s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]        s2_data_q, s2_data_d;
  logic                    s2_carry_q, s2_carry_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    adv;
  logic [NUM_CH*WIDTH-1:0] masked;
  logic [SUM_W-1:0]        sum;
  logic                    carry;
  logic [WIDTH-1:0]        result;

  assign adv      = !s2_valid_q || out_ready;
  assign in_ready = adv;

  always_comb begin
    masked = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (in_mask[k]) masked[k*WIDTH +: WIDTH] = in_data[k*WIDTH +: WIDTH];
    end
  end

  mixer_adder_tree #(
    .WIDTH  (WIDTH),
    .NUM_CH (NUM_CH),
    .SUM_W  (SUM_W)
  ) u_tree (
    .samples_i (s1_data_q),
    .cin_i     (s1_cin_q),
    .sum_o     (sum)
  );

  assign carry = |sum[SUM_W-1:WIDTH];

`ifdef MIXER_SATURATE_EN
  assign result = carry ? '1 : sum[WIDTH-1:0];
`else
  assign result = sum[WIDTH-1:0];
`endif

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_cin_d   = s1_cin_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_carry_d = s2_carry_q;
    cnt_d      = cnt_q;
    if (adv) begin
      s1_valid_d = in_valid;
      s1_data_d  = masked;
      s1_cin_d   = in_cin;
      s2_valid_d = s1_valid_q;
      // Bubbles leave the last delivered result on out_data.
      if (s1_valid_q) begin
        s2_data_d  = result;
        s2_carry_d = carry;
      end
    end
    if (s2_valid_q && out_ready && s2_carry_q) begin
      cnt_d = CNT_W'(sat_inc(32'(cnt_q), 32'(CNT_ONES)));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_cin_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_carry_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_cin_q   <= s1_cin_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_carry_q <= s2_carry_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_carry = s2_carry_q;
  assign ovf_count = cnt_q;

endmodule
